arb_requester: RTL

//   Requester-side agent for one port of the dual-priority round-robin arbiter.

---
 rtl/arb_requester_if.sv | 30 +++
 rtl/arb_requester.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester_if.sv
// Handshake bundle between one arbiter-port requester and its neighbours:
// upstream entry channel, arbiter request/grant pair and downstream output channel.
interface arb_requester_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_hi;
    logic              hp_req;
    logic              lp_req;
    logic              grant;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_hi;
    logic              out_aged;

    // Environment side: feeds entries, returns grants, accepts outputs.
    modport master (
        output in_valid, in_data, in_hi, grant, out_ready,
        input  in_ready, hp_req, lp_req, out_valid, out_data, out_hi, out_aged
    );

    // Requester side.
    modport slave (
        input  in_valid, in_data, in_hi, grant, out_ready,
        output in_ready, hp_req, lp_req, out_valid, out_data, out_hi, out_aged
    );
endinterface

// File: rtl/arb_requester.sv
// Requester agent for one port of a dual-priority round-robin arbiter.
// Queues {hi,data} entries, raises hp/lp request for the head, captures the head on
// this port's registered grant bit and forwards it downstream. Waiting low-priority
// heads are promoted to high priority after AGE_LIMIT request cycles.
module arb_requester #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int AGE_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    arb_requester_if.slave             bus,
    output logic                       stray_grant,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Saturating age increment; holds at AGE_LIMIT.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_W'(AGE_LIMIT)) ? a : a + AGE_W'(1);
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_W:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // Control
    state_t             r_state;
    state_t             w_next_state;
    logic [AGE_W-1:0]   r_age;
    logic [AGE_W-1:0]   w_age_next;
    logic               r_promoted;
    logic               r_stray;

    // Output register
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_hi;
    logic               r_out_aged;

    // Combinational
    logic               w_in_ready;
    logic               w_push;
    logic               w_capture;
    logic               w_out_fire;
    logic [DATA_W:0]    w_head;
    logic               w_head_hi;
    logic               w_hp_req;
    logic               w_lp_req;
    logic               w_age_inc;

    assign w_in_ready = rst_n && (r_count < CNT_W'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_capture  = (r_state == S_REQ) && bus.grant;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_hi  = w_head[DATA_W];

    // Aging only runs while a low-priority request is actually pending.
    assign w_age_inc  = w_lp_req && (AGE_LIMIT != 0) && (r_age != AGE_W'(AGE_LIMIT));
    assign w_age_next = age_sat_inc(r_age);

    // Entry storage; writes only on accepted pushes, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_hi, bus.in_data};
        end
    end

    // FIFO pointers and occupancy; a push and a capture in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_capture) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_capture})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state; HOLD waits for the output register to drain, which also
    // covers the arbiter's one-cycle registered-grant lag.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.grant) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!r_out_valid) begin
                    w_next_state = (r_count != '0) ? S_REQ : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: requests decode from registered state and head only, never from grant.
    always_comb begin
        w_hp_req = 1'b0;
        w_lp_req = 1'b0;
        if (r_state == S_REQ) begin
            w_hp_req = w_head_hi || r_promoted;
            w_lp_req = !(w_head_hi || r_promoted);
        end
    end

    // Age counter and promotion flag; both restart for every new head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_age      <= '0;
            r_promoted <= 1'b0;
        end else if (w_capture) begin
            r_age      <= '0;
            r_promoted <= 1'b0;
        end else if (w_age_inc) begin
            r_age <= w_age_next;
            if (w_age_next == AGE_W'(AGE_LIMIT)) begin
                r_promoted <= 1'b1;
            end
        end
    end

    // Output register: loads on grant capture, holds until the downstream handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_hi    <= 1'b0;
            r_out_aged  <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[DATA_W-1:0];
            r_out_hi    <= w_head_hi;
            r_out_aged  <= r_promoted;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky flag for a grant arriving when this port is not requesting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stray <= 1'b0;
        end else if (bus.grant && (r_state != S_REQ)) begin
            r_stray <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.hp_req    = w_hp_req;
    assign bus.lp_req    = w_lp_req;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_hi    = r_out_hi;
    assign bus.out_aged  = r_out_aged;
    assign stray_grant   = r_stray;
    assign fifo_count    = r_count;

endmodule
